// File: rtl/mux_rr_reg_if.sv
// Handshake bundle between N producer channels, the channel mux and one consumer.
// master = producers/consumer side, slave = the mux itself.
interface mux_rr_reg_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/mux_rr_reg.sv
// N:1 channel mux, fixed-select or round-robin grant, single output register.
// Latency: 1 cycle from input transfer to out_valid; 1 word/cycle sustained.
// Backpressure: output word held while out_ready=0; all in_ready low meanwhile.
module mux_rr_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_rr_reg_if.slave   bus
);

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_ch_q,   out_ch_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    rr_ptr_q,   rr_ptr_d;

    logic                gnt_vld;
    logic [SEL_W-1:0]    gnt_idx;
    logic [SEL_W-1:0]    scan_idx;
    logic                load_en;
    logic                xfer;
    logic [CHANNELS-1:0] in_ready_w;

    // Scan indices are reduced mod CHANNELS, so non-power-of-two sizes never
    // touch a nonexistent channel.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        if (!bus.mode) begin
            if (int'(bus.sel) < CHANNELS) begin
                if (bus.in_valid[bus.sel]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = bus.sel;
                end
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                scan_idx = SEL_W'((int'(rr_ptr_q) + i) % CHANNELS);
                if (!gnt_vld && bus.in_valid[scan_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
        end
    end

    assign load_en = !out_valid_q || bus.out_ready;
    assign xfer    = rst_n && gnt_vld && load_en;

    always_comb begin
        in_ready_w = '0;
        if (xfer) begin
            in_ready_w[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = bus.in_data[int'(gnt_idx)*WIDTH +: WIDTH];
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            if (bus.mode) begin
                rr_ptr_d = (gnt_idx == SEL_W'(CHANNELS-1)) ? '0 : gnt_idx + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// Bench for mux_rr_reg: directed scenarios plus a per-cycle reference model.
module tb_mux_rr_reg;
    localparam int W = 4;
    localparam int C = 4;
    localparam int S = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_rr_reg_if #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) bus();

    mux_rr_reg #(.WIDTH(W), .CHANNELS(C), .SEL_W(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the word register is a one-slot buffer; grant is the
    // first valid channel in rotation order starting from the pointer.
    logic         m_vld;
    logic [W-1:0] m_dat;
    logic [S-1:0] m_ch;
    int           m_ptr;
    int           m_g;

    function automatic int model_grant(input logic md, input logic [S-1:0] s,
                                       input logic [C-1:0] v, input int ptr);
        if (!md) begin
            if (int'(s) < C && v[s]) return int'(s);
            return -1;
        end
        for (int k = 0; k < C; k++) begin
            if (v[(ptr + k) % C]) return (ptr + k) % C;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_vld = 1'b0; m_dat = '0; m_ch = '0; m_ptr = 0;
        end else begin
            m_g = model_grant(bus.mode, bus.sel, bus.in_valid, m_ptr);
            if (m_g >= 0 && (!m_vld || bus.out_ready)) begin
                m_vld = 1'b1;
                m_dat = bus.in_data[m_g*W +: W];
                m_ch  = S'(m_g);
                if (bus.mode) m_ptr = (m_g + 1) % C;
            end else if (bus.out_ready) begin
                m_vld = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [C-1:0] exp_rdy;
        int g;
        exp_rdy = '0;
        g = model_grant(bus.mode, bus.sel, bus.in_valid, m_ptr);
        if (rst_n && g >= 0 && (!m_vld || bus.out_ready)) exp_rdy[g] = 1'b1;
        check("model out_valid", 32'(bus.out_valid), 32'(m_vld));
        check("model out_data",  32'(bus.out_data),  32'(m_dat));
        check("model out_ch",    32'(bus.out_ch),    32'(m_ch));
        check("model in_ready",  32'(bus.in_ready),  32'(exp_rdy));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: simulation exceeded time limit");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp1 [4];
        logic [1:0] exp3 [3];
        exp1 = '{4'h1, 4'h3, 4'h5, 4'hA};
        exp3 = '{2'd3, 2'd0, 2'd3};

        bus.mode      = 1'b0;
        bus.sel       = 2'd0;
        bus.in_data   = 16'hA531;
        bus.in_valid  = 4'hF;
        bus.out_ready = 1'b1;

        // Reset state, including in_ready suppressed while in reset
        #12;
        check("rst out_valid", 32'(bus.out_valid), 0);
        check("rst out_data",  32'(bus.out_data),  0);
        check("rst out_ch",    32'(bus.out_ch),    0);
        check("rst in_ready",  32'(bus.in_ready),  0);
        rst_n = 1'b1;

        // Fixed select walking sel 0..3
        for (int i = 0; i < 4; i++) begin
            bus.sel = S'(i);
            tick();
            check("fixed out_data",  32'(bus.out_data),  32'(exp1[i]));
            check("fixed out_ch",    32'(bus.out_ch),    32'(i));
            check("fixed out_valid", 32'(bus.out_valid), 1);
        end

        // Round-robin with every channel valid, nine grants ending on ch0
        bus.mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("rr out_ch",    32'(bus.out_ch),    32'(i % 4));
            check("rr out_valid", 32'(bus.out_valid), 1);
        end

        // Skip and wrap: only ch0 and ch3 valid, pointer at 1
        bus.in_valid = 4'b1001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("skip out_ch", 32'(bus.out_ch), 32'(exp3[i]));
        end

        // Backpressure holds ch3 word (data A)
        bus.out_ready = 1'b0;
        bus.in_valid  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall out_valid", 32'(bus.out_valid), 1);
            check("stall out_ch",    32'(bus.out_ch),    3);
            check("stall out_data",  32'(bus.out_data),  32'hA);
            check("stall in_ready",  32'(bus.in_ready),  0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("release in_ready", 32'(bus.in_ready), 32'b0001);
        tick();
        check("release out_ch",   32'(bus.out_ch),   0);
        check("release out_data", 32'(bus.out_data), 1);

        // Fixed select on an idle channel: no grant, register drains
        bus.mode     = 1'b0;
        bus.sel      = 2'd2;
        bus.in_valid = 4'b1011;
        #1;
        check("idle sel in_ready", 32'(bus.in_ready), 0);
        tick();
        check("idle out_valid", 32'(bus.out_valid), 0);
        check("idle out_ch",    32'(bus.out_ch),    0);
        check("idle out_data",  32'(bus.out_data),  1);

        // Mid-cycle reset during a round-robin stream
        bus.mode     = 1'b1;
        bus.in_valid = 4'hF;
        tick();
        check("pre-rst out_ch", 32'(bus.out_ch), 1);
        tick();
        check("pre-rst out_ch", 32'(bus.out_ch), 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", 32'(bus.out_valid), 0);
        check("async rst out_data",  32'(bus.out_data),  0);
        check("async rst out_ch",    32'(bus.out_ch),    0);
        check("async rst in_ready",  32'(bus.in_ready),  0);
        #3;
        rst_n = 1'b1;
        tick();
        check("post-rst out_ch",   32'(bus.out_ch),   0);
        check("post-rst out_data", 32'(bus.out_data), 1);
        tick();
        check("post-rst out_ch",   32'(bus.out_ch),   1);
        check("post-rst out_data", 32'(bus.out_data), 3);

        tick();
        tick();
        summary();
        $finish;
    end
endmodule
